// File: rtl/filter_chunk_loader_pkg.sv
// Shared definitions for the filter chunk loader: the default bus and chunk
// geometry, width helpers, the bank completion states and the nnz count type.
// Optional feature macro: FILTER_NNZ_COUNT_EN (per-bank nonzero byte counts).
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 2
`endif

package filter_chunk_loader_pkg;

  localparam int unsigned DEF_BUS_SIZE       = `BUS_SIZE;
  localparam int unsigned DEF_WR_DAT_CYC_NUM = `WR_DAT_CYC_NUM;

  // Width of the beat index within a chunk.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  // Width able to hold a nonzero byte count of 0..bus*cyc.
  function automatic int unsigned nnz_width(input int unsigned bus, input int unsigned cyc);
    return $clog2(bus * cyc) + 1;
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WR_DAT_CYC_NUM);
  localparam int unsigned DEF_NNZ_W = nnz_width(DEF_BUS_SIZE, DEF_WR_DAT_CYC_NUM);

  typedef logic [DEF_NNZ_W-1:0] nnz_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/filter_chunk_loader_sparse_compress.sv
// Combinational beat compressor: one bit per nonzero byte, and the nonzero
// bytes packed towards element 0 by a running prefix count of nonzero flags.
module filter_chunk_loader_sparse_compress
  import filter_chunk_loader_pkg::*;
#(
  parameter int unsigned BUS_SIZE = DEF_BUS_SIZE
) (
  input  logic [BUS_SIZE*8-1:0] data_i,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o
);

  // Scan elements in order; each nonzero byte lands at the slot given by the
  // number of nonzero bytes below it.
  always_comb begin
    int unsigned pos;
    pos            = 0;
    sparsemap_o    = '0;
    nonzero_data_o = '0;
    for (int unsigned i = 0; i < BUS_SIZE; i++) begin
      if (data_i[i*8 +: 8] != 8'h00) begin
        sparsemap_o[i]             = 1'b1;
        nonzero_data_o[pos*8 +: 8] = data_i[i*8 +: 8];
        pos                        = pos + 1;
      end
    end
  end

endmodule

// File: rtl/filter_chunk_loader.sv
// Write-side controller of the filter ping-pong chunk stage: compresses each
// accepted beat, registers it onto the chunk write port and tracks which bank
// holds a complete chunk for the reader.
// Optional feature macro: FILTER_NNZ_COUNT_EN adds chunk_nnz_o.
module filter_chunk_loader
  import filter_chunk_loader_pkg::*;
#(
  parameter int unsigned BUS_SIZE       = DEF_BUS_SIZE,
  parameter int unsigned WR_DAT_CYC_NUM = DEF_WR_DAT_CYC_NUM,
  localparam int unsigned CNT_W         = cnt_width(WR_DAT_CYC_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic                  rd_sel_o,
  output logic                  chunk_ready_o,
  input  logic                  rd_release_i
`ifdef FILTER_NNZ_COUNT_EN
  ,
  output logic [nnz_width(BUS_SIZE, WR_DAT_CYC_NUM)-1:0] chunk_nnz_o
`endif
);

  logic             in_bank_q, in_bank_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  bank_state_e      bank_state_q [2];
  bank_state_e      bank_state_d [2];
  logic [1:0]       full;
  logic             accept;
  logic             last_beat;
  logic             release_acc;

  logic [BUS_SIZE-1:0]   cmp_map;
  logic [BUS_SIZE*8-1:0] cmp_data;

  logic                  wr_valid_q;
  logic [BUS_SIZE-1:0]   wr_map_q;
  logic [BUS_SIZE*8-1:0] wr_data_q;
  logic [CNT_W-1:0]      wr_count_q;
  logic                  wr_sel_q;

  filter_chunk_loader_sparse_compress #(
    .BUS_SIZE(BUS_SIZE)
  ) u_sparse_compress (
    .data_i         (in_data_i),
    .sparsemap_o    (cmp_map),
    .nonzero_data_o (cmp_data)
  );

  assign full[0]       = (bank_state_q[0] == BANK_FULL);
  assign full[1]       = (bank_state_q[1] == BANK_FULL);
  assign in_ready_o    = !rst_i && !full[in_bank_q];
  assign accept        = in_valid_i && in_ready_o;
  assign last_beat     = (beat_cnt_q == CNT_W'(WR_DAT_CYC_NUM - 1));
  assign chunk_ready_o = full[rd_bank_q];
  assign release_acc   = rd_release_i && chunk_ready_o;

  // Write pointer advances per accepted beat; read pointer per accepted release.
  always_comb begin
    in_bank_d  = in_bank_q;
    beat_cnt_d = beat_cnt_q;
    rd_bank_d  = rd_bank_q;
    if (accept) begin
      if (last_beat) begin
        beat_cnt_d = '0;
        in_bank_d  = !in_bank_q;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    if (release_acc) begin
      rd_bank_d = !rd_bank_q;
    end
  end

  // Per-bank completion: filling on first beat, full on last beat, empty on release.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      bank_state_d[b] = bank_state_q[b];
      unique case (bank_state_q[b])
        BANK_EMPTY: begin
          if (accept && (in_bank_q == 1'(b))) begin
            bank_state_d[b] = BANK_FILLING;
          end
        end
        BANK_FILLING: begin
          if (accept && last_beat && (in_bank_q == 1'(b))) begin
            bank_state_d[b] = BANK_FULL;
          end
        end
        BANK_FULL: begin
          if (release_acc && (rd_bank_q == 1'(b))) begin
            bank_state_d[b] = BANK_EMPTY;
          end
        end
        default: bank_state_d[b] = BANK_EMPTY;
      endcase
    end
  end

  // Control state register; reset abandons any partial chunk.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_bank_q       <= 1'b0;
      beat_cnt_q      <= '0;
      rd_bank_q       <= 1'b0;
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
    end else begin
      in_bank_q       <= in_bank_d;
      beat_cnt_q      <= beat_cnt_d;
      rd_bank_q       <= rd_bank_d;
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
    end
  end

  // Registered write port: one cycle after the accepting edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_valid_q <= 1'b0;
      wr_map_q   <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      wr_sel_q   <= 1'b0;
    end else begin
      wr_valid_q <= accept;
      if (accept) begin
        wr_map_q   <= cmp_map;
        wr_data_q  <= cmp_data;
        wr_count_q <= beat_cnt_q;
        wr_sel_q   <= in_bank_q;
      end
    end
  end

  assign wr_valid_o        = wr_valid_q;
  assign wr_sparsemap_o    = wr_map_q;
  assign wr_nonzero_data_o = wr_data_q;
  assign wr_count_o        = wr_count_q;
  assign wr_sel_o          = wr_sel_q;
  assign rd_sel_o          = rd_bank_q;

`ifdef FILTER_NNZ_COUNT_EN
  localparam int unsigned NNZ_W = nnz_width(BUS_SIZE, WR_DAT_CYC_NUM);

  logic [NNZ_W-1:0] nnz_q [2];
  logic [NNZ_W-1:0] nnz_d [2];
  logic [NNZ_W-1:0] beat_pop;

  // Nonzero bytes in the beat being accepted.
  always_comb begin
    beat_pop = '0;
    for (int unsigned i = 0; i < BUS_SIZE; i++) begin
      beat_pop = beat_pop + NNZ_W'(cmp_map[i]);
    end
  end

  // Count restarts on a bank's first beat and is untouched while the bank is full.
  always_comb begin
    nnz_d[0] = nnz_q[0];
    nnz_d[1] = nnz_q[1];
    if (accept) begin
      nnz_d[in_bank_q] = (beat_cnt_q == '0) ? beat_pop : nnz_q[in_bank_q] + beat_pop;
    end
  end

  // Per-bank count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nnz_q[0] <= '0;
      nnz_q[1] <= '0;
    end else begin
      nnz_q[0] <= nnz_d[0];
      nnz_q[1] <= nnz_d[1];
    end
  end

  assign chunk_nnz_o = nnz_q[rd_bank_q];
`endif

endmodule

// File: tb/tb_filter_chunk_loader.sv
// Bench for filter_chunk_loader (BUS_SIZE=4, WR_DAT_CYC_NUM=2): a directed
// vector table followed by randomized traffic against a counting model.
// Optional feature macro: FILTER_NNZ_COUNT_EN.
module tb_filter_chunk_loader;

  localparam int unsigned BUS = 4;
  localparam int unsigned CYC = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] in_data_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  wr_sparsemap_o;
  logic [31:0] wr_nonzero_data_o;
  logic        wr_valid_o;
  logic [0:0]  wr_count_o;
  logic        wr_sel_o;
  logic        rd_sel_o;
  logic        chunk_ready_o;
  logic        rd_release_i = 1'b0;
`ifdef FILTER_NNZ_COUNT_EN
  logic [3:0]  chunk_nnz_o;
`endif

  always #5 clk = ~clk;

  filter_chunk_loader #(
    .BUS_SIZE       (BUS),
    .WR_DAT_CYC_NUM (CYC)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .in_data_i         (in_data_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sel_o          (wr_sel_o),
    .rd_sel_o          (rd_sel_o),
    .chunk_ready_o     (chunk_ready_o),
    .rd_release_i      (rd_release_i)
`ifdef FILTER_NNZ_COUNT_EN
    ,
    .chunk_nnz_o       (chunk_nnz_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic        rel;
    logic [31:0] data;
    logic        e_ready;
    logic        e_wv;
    logic [3:0]  e_map;
    logic [31:0] e_data;
    logic        e_cnt;
    logic        e_sel;
    logic        e_rd;
    logic        e_cr;
    logic [3:0]  e_nnz;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic rel, input logic [31:0] d,
                              input logic er, input logic ewv, input logic [3:0] em,
                              input logic [31:0] ed, input logic ec, input logic es,
                              input logic erd, input logic ecr, input logic [3:0] en);
    vec_t t;
    t.rst = r; t.valid = v; t.rel = rel; t.data = d;
    t.e_ready = er; t.e_wv = ewv; t.e_map = em; t.e_data = ed;
    t.e_cnt = ec; t.e_sel = es; t.e_rd = erd; t.e_cr = ecr; t.e_nnz = en;
    return t;
  endfunction

  // Reference compression: nonzero bytes collected in order, then laid out from slot 0.
  function automatic void ref_compress(input logic [31:0] d, output logic [3:0] m, output logic [31:0] p);
    logic [7:0] nz[$];
    m = '0;
    p = '0;
    for (int i = 0; i < BUS; i++) begin
      if (d[i*8 +: 8] != 8'h00) begin
        m[i] = 1'b1;
        nz.push_back(d[i*8 +: 8]);
      end
    end
    foreach (nz[k]) p[k*8 +: 8] = nz[k];
  endfunction

  task automatic drive(input logic r, input logic v, input logic rel, input logic [31:0] d);
    @(negedge clk);
    rst_i        = r;
    in_valid_i   = v;
    rd_release_i = rel;
    in_data_i    = d;
    #1;
  endtask

  vec_t tbl[18];

  // Model state: totals of beats accepted, chunks completed and chunks released.
  int          m_beats, m_written, m_released;
  logic [3:0]  m_bank_nnz[2];
  logic        e_wv, e_cnt, e_sel;
  logic [3:0]  e_map;
  logic [31:0] e_data;

  initial begin
    tbl[0]  = mk(1,0,0,32'h0,        0,0,4'h0,32'h0,        0,0,0,0,4'd0);
    tbl[1]  = mk(0,1,0,32'h07000500, 1,1,4'hA,32'h00000705, 0,0,0,0,4'd0);
    tbl[2]  = mk(0,1,0,32'h00000011, 1,1,4'h1,32'h00000011, 1,0,0,1,4'd3);
    tbl[3]  = mk(0,1,0,32'h22000000, 1,1,4'h8,32'h00000022, 0,1,0,1,4'd3);
    tbl[4]  = mk(0,1,0,32'h00330000, 1,1,4'h4,32'h00000033, 1,1,0,1,4'd3);
    tbl[5]  = mk(0,1,0,32'h44444444, 0,0,4'h0,32'h0,        0,0,0,1,4'd3);
    tbl[6]  = mk(0,1,1,32'h44444444, 0,0,4'h0,32'h0,        0,0,1,1,4'd2);
    tbl[7]  = mk(0,1,0,32'h44444444, 1,1,4'hF,32'h44444444, 0,0,1,1,4'd2);
    tbl[8]  = mk(0,0,1,32'h0,        1,0,4'h0,32'h0,        0,0,0,0,4'd0);
    tbl[9]  = mk(0,0,1,32'h0,        1,0,4'h0,32'h0,        0,0,0,0,4'd0);
    tbl[10] = mk(0,1,0,32'h00000001, 1,1,4'h1,32'h00000001, 1,0,0,1,4'd5);
    tbl[11] = mk(0,1,1,32'h00000100, 1,1,4'h2,32'h00000001, 0,1,1,0,4'd0);
    tbl[12] = mk(1,1,0,32'h12345678, 0,0,4'h0,32'h0,        0,0,0,0,4'd0);
    tbl[13] = mk(0,1,0,32'h000000FF, 1,1,4'h1,32'h000000FF, 0,0,0,0,4'd0);
    tbl[14] = mk(0,1,0,32'hFF000000, 1,1,4'h8,32'h000000FF, 1,0,0,1,4'd2);
    tbl[15] = mk(0,0,1,32'h0,        1,0,4'h0,32'h0,        0,0,1,0,4'd0);
    tbl[16] = mk(0,1,0,32'h02000001, 1,1,4'h9,32'h00000201, 0,1,1,0,4'd0);
    tbl[17] = mk(0,1,0,32'h00000000, 1,1,4'h0,32'h00000000, 1,1,1,1,4'd2);

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].rel, tbl[i].data);
      chk("in_ready", i, 32'(in_ready_o), 32'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      chk("wr_valid", i, 32'(wr_valid_o), 32'(tbl[i].e_wv));
      if (tbl[i].e_wv || tbl[i].rst) begin
        chk("wr_sparsemap", i, 32'(wr_sparsemap_o), 32'(tbl[i].e_map));
        chk("wr_nonzero_data", i, wr_nonzero_data_o, tbl[i].e_data);
        chk("wr_count", i, 32'(wr_count_o), 32'(tbl[i].e_cnt));
        chk("wr_sel", i, 32'(wr_sel_o), 32'(tbl[i].e_sel));
      end
      chk("rd_sel", i, 32'(rd_sel_o), 32'(tbl[i].e_rd));
      chk("chunk_ready", i, 32'(chunk_ready_o), 32'(tbl[i].e_cr));
`ifdef FILTER_NNZ_COUNT_EN
      if (tbl[i].e_cr || tbl[i].rst) chk("chunk_nnz", i, 32'(chunk_nnz_o), 32'(tbl[i].e_nnz));
`endif
    end

    // Randomized traffic; first step is a reset so the model starts clean.
    for (int n = 0; n < 3000; n++) begin
      logic        r, v, rel, exp_ready, acc, racc;
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] p;
      int          bank;
      r   = (n == 0) || ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rel = ($urandom_range(0, 9) < 3);
      for (int b = 0; b < BUS; b++) begin
        d[b*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      drive(r, v, rel, d);

      exp_ready = !r && ((m_written - m_released) < 2);
      chk("rnd_in_ready", n, 32'(in_ready_o), 32'(exp_ready));
      acc  = v && exp_ready;
      racc = !r && rel && (m_written > m_released);

      if (r) begin
        m_beats = 0; m_written = 0; m_released = 0;
        m_bank_nnz[0] = '0; m_bank_nnz[1] = '0;
        e_wv = 0; e_map = '0; e_data = '0; e_cnt = 0; e_sel = 0;
      end else begin
        e_wv = acc;
        if (acc) begin
          ref_compress(d, m, p);
          bank   = m_written % 2;
          e_map  = m;
          e_data = p;
          e_cnt  = 1'(m_beats % CYC);
          e_sel  = 1'(bank);
          if ((m_beats % CYC) == 0) m_bank_nnz[bank] = 4'($countones(m));
          else                      m_bank_nnz[bank] = m_bank_nnz[bank] + 4'($countones(m));
          m_beats++;
          if ((m_beats % CYC) == 0) m_written++;
        end
        if (racc) m_released++;
      end

      @(posedge clk);
      #1;
      chk("rnd_wr_valid", n, 32'(wr_valid_o), 32'(e_wv));
      if (e_wv || r) begin
        chk("rnd_wr_sparsemap", n, 32'(wr_sparsemap_o), 32'(e_map));
        chk("rnd_wr_nonzero_data", n, wr_nonzero_data_o, e_data);
        chk("rnd_wr_count", n, 32'(wr_count_o), 32'(e_cnt));
        chk("rnd_wr_sel", n, 32'(wr_sel_o), 32'(e_sel));
      end
      chk("rnd_rd_sel", n, 32'(rd_sel_o), 32'(m_released % 2));
      chk("rnd_chunk_ready", n, 32'(chunk_ready_o), 32'(m_written > m_released));
`ifdef FILTER_NNZ_COUNT_EN
      if (m_written > m_released) chk("rnd_chunk_nnz", n, 32'(chunk_nnz_o), 32'(m_bank_nnz[m_released % 2]));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
